set_region_counter: RTL and testbench
=====================================

// Module: set_region_counter
// PURPOSE
//  Parametrised successor of the two-circle lattice-point counter. Scans a GRID_N x GRID_N integer
//  grid (points 1..GRID_N per axis) one point per cycle and counts points satisfying a set
//  expression over circles A and B. Adds union mode, operand/mode capture at start and generic widths.
//  Sits behind the host command interface; host pulses en and waits for valid.
// PARAMETERS
//  COORD_W  4   width of each centre coordinate (unsigned)
//  RAD_W    4   width of each radius (unsigned)
//  GRID_N   8   grid points per axis, 1..2**COORD_W-1
//  CNT_W    $clog2(GRID_N*GRID_N+1)  result width (derived localparam, not overridable)
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              asynchronous active-low reset
//  en         in   1              start request; sampled only in IDLE
//  central    in   4*COORD_W      {xA,yA,xB,yB}, xA in MSBs
//  radius     in   2*RAD_W        {rA,rB}, rA in MSBs
//  mode       in   2              00 A, 01 A&B, 10 A^B, 11 A|B
//  busy       out  1              scan in progress
//  valid      out  1              one-cycle result strobe
//  candidate  out  CNT_W          point count; held until next accepted start
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, busy=0, valid=0, candidate=0, scan point=(1,1).
//  States: IDLE -> SCAN on en=1; SCAN -> IDLE after point (GRID_N,GRID_N).
//  Accept edge (IDLE, en=1): latch central/radius/mode, candidate<=0, busy<=1, point<=(1,1).
//  SCAN: each edge evaluates current point, candidate += hit, x increments; x==GRID_N wraps to 1, y+1.
//  Last point edge: final add, busy<=0, valid<=1, state IDLE. valid low on every other edge.
//  Latency: valid high in cycle starting GRID_N*GRID_N edges after the accept edge.
//  en while busy ignored; input changes during SCAN have no effect (captured copies used).
//  en=1 in the valid cycle is accepted (back-to-back); candidate clears on that edge.
//  Inside test: dx=|x-xc|, dy=|y-yc|; in = dx*dx+dy*dy <= r*r, evaluated at 2*max(COORD_W,RAD_W)+1 bits, no overflow.
//  r=0: only the centre point is inside. Centres at 0 or outside grid are legal.
//  candidate never saturates (CNT_W holds GRID_N^2).
// CONFIGURATION
//  SET_ABORT_EN defined: extra input abort (1 bit). abort=1 in SCAN -> IDLE next edge, busy<=0,
//   valid stays 0, candidate<=0. abort in IDLE ignored; abort beats the last-point edge.
//  Undefined: no abort port; a scan always runs to completion.
// STRUCTURE
//  Package set_pkg: mode encodings (MODE_A, MODE_AND, MODE_XOR, MODE_OR), state enum {IDLE,SCAN}.
//  Sub-module set_point_test (combinational: x,y,xc,yc,r -> in), instantiated for A and B.
// TESTING (defaults)
//  A=(4,4) r=2, mode 00 -> valid after 64 cycles, candidate=13.
//  A=(4,4) r=2, B=(6,4) r=2: mode 01 -> 5, mode 10 -> 16, mode 11 -> 21; run back-to-back via en in valid cycle.
//  A=(1,1) r=0 -> 1; A=(0,0) r=1 -> 0; A=(8,8) r=15 -> 64 (width/overflow check).
//  Pulse en and change central/mode mid-scan -> result unaffected, no second scan started.
//  Assert rst=0 at cycle 30 of a scan -> busy/valid/candidate 0 immediately; new scan after release correct.
//  SET_ABORT_EN: abort at cycle 20 -> busy 0 next cycle, no valid; next scan returns correct 13.

Source files
------------

// File: rtl/set_pkg.sv
// Shared types for the two-circle set-region counter: set-expression mode
// encodings and the scan controller state.
package set_pkg;

    typedef enum logic [1:0] {
        MODE_A   = 2'b00,
        MODE_AND = 2'b01,
        MODE_XOR = 2'b10,
        MODE_OR  = 2'b11
    } mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : set_pkg

// File: rtl/set_point_test.sv
// Combinational point-in-circle test: (x-xc)^2 + (y-yc)^2 <= r^2, evaluated
// wide enough that neither side can overflow.
module set_point_test
    import set_pkg::*;
#(
    parameter int COORD_W = 4,
    parameter int RAD_W   = 4
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] xc,
    input  logic [COORD_W-1:0] yc,
    input  logic [RAD_W-1:0]   r,
    output logic               hit
);

    localparam int TW = 2 * max_int(COORD_W, RAD_W) + 1;

    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [TW-1:0]      dx_w;
    logic [TW-1:0]      dy_w;
    logic [TW-1:0]      r_w;
    logic [TW-1:0]      dist2;
    logic [TW-1:0]      rad2;

    assign dx    = (x >= xc) ? (x - xc) : (xc - x);
    assign dy    = (y >= yc) ? (y - yc) : (yc - y);
    assign dx_w  = TW'(dx);
    assign dy_w  = TW'(dy);
    assign r_w   = TW'(r);
    assign dist2 = dx_w * dx_w + dy_w * dy_w;
    assign rad2  = r_w * r_w;
    assign hit   = (dist2 <= rad2);

endmodule : set_point_test

// File: rtl/set_region_counter.sv
// Scans a GRID_N x GRID_N lattice one point per cycle and counts points in a
// set expression over circles A and B. Define SET_ABORT_EN to add the abort input.
module set_region_counter
    import set_pkg::*;
#(
    parameter int  COORD_W = 4,
    parameter int  RAD_W   = 4,
    parameter int  GRID_N  = 8,
    localparam int CNT_W   = $clog2(GRID_N * GRID_N + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [4*COORD_W-1:0] central,
    input  logic [2*RAD_W-1:0]   radius,
    input  logic [1:0]           mode,
`ifdef SET_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 busy,
    output logic                 valid,
    output logic [CNT_W-1:0]     candidate
);

    localparam logic [COORD_W-1:0] LAST  = COORD_W'(GRID_N);
    localparam logic [COORD_W-1:0] FIRST = COORD_W'(1);

    state_t             state;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] xa_q;
    logic [COORD_W-1:0] ya_q;
    logic [COORD_W-1:0] xb_q;
    logic [COORD_W-1:0] yb_q;
    logic [RAD_W-1:0]   ra_q;
    logic [RAD_W-1:0]   rb_q;
    mode_t              mode_q;
    logic               hit_a;
    logic               hit_b;
    logic               hit;
    logic               abort_req;

`ifdef SET_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    set_point_test #(.COORD_W(COORD_W), .RAD_W(RAD_W)) u_test_a (
        .x   (x),
        .y   (y),
        .xc  (xa_q),
        .yc  (ya_q),
        .r   (ra_q),
        .hit (hit_a)
    );

    set_point_test #(.COORD_W(COORD_W), .RAD_W(RAD_W)) u_test_b (
        .x   (x),
        .y   (y),
        .xc  (xb_q),
        .yc  (yb_q),
        .r   (rb_q),
        .hit (hit_b)
    );

    always_comb begin
        // NOTE: default first so every path assigns hit and no latch is inferred.
        hit = 1'b0;
        case (mode_q)
            MODE_A:   hit = hit_a;
            MODE_AND: hit = hit_a & hit_b;
            MODE_XOR: hit = hit_a ^ hit_b;
            MODE_OR:  hit = hit_a | hit_b;
            default:  hit = 1'b0;
        endcase
    end

    // NOTE: non-blocking assignments throughout so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            valid     <= 1'b0;
            candidate <= '0;
            x         <= FIRST;
            y         <= FIRST;
            xa_q      <= '0;
            ya_q      <= '0;
            xb_q      <= '0;
            yb_q      <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            mode_q    <= MODE_A;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        xa_q      <= central[4*COORD_W-1 -: COORD_W];
                        ya_q      <= central[3*COORD_W-1 -: COORD_W];
                        xb_q      <= central[2*COORD_W-1 -: COORD_W];
                        yb_q      <= central[COORD_W-1:0];
                        ra_q      <= radius[2*RAD_W-1 -: RAD_W];
                        rb_q      <= radius[RAD_W-1:0];
                        mode_q    <= mode_t'(mode);
                        candidate <= '0;
                        busy      <= 1'b1;
                        x         <= FIRST;
                        y         <= FIRST;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (abort_req) begin
                        // Abort wins over the last-point edge: no strobe, count discarded.
                        candidate <= '0;
                        busy      <= 1'b0;
                        x         <= FIRST;
                        y         <= FIRST;
                        state     <= IDLE;
                    end else begin
                        candidate <= candidate + CNT_W'(hit);
                        if (x == LAST) begin
                            x <= FIRST;
                            if (y == LAST) begin
                                y     <= FIRST;
                                busy  <= 1'b0;
                                valid <= 1'b1;
                                state <= IDLE;
                            end else begin
                                y <= y + FIRST;
                            end
                        end else begin
                            x <= x + FIRST;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule : set_region_counter

// File: tb/tb_set_region_counter.sv
// Self-checking bench for set_region_counter: directed scenarios plus random
// operands checked against a grid-enumeration reference model.
module tb_set_region_counter;

    localparam int COORD_W = 4;
    localparam int RAD_W   = 4;
    localparam int GRID_N  = 8;
    localparam int CNT_W   = $clog2(GRID_N * GRID_N + 1);
    localparam int NPTS    = GRID_N * GRID_N;

    logic                 clk;
    logic                 rst;
    logic                 en;
    logic [4*COORD_W-1:0] central;
    logic [2*RAD_W-1:0]   radius;
    logic [1:0]           mode;
`ifdef SET_ABORT_EN
    logic                 abort;
`endif
    logic                 busy;
    logic                 valid;
    logic [CNT_W-1:0]     candidate;

    int n_tests = 0;
    int n_fail  = 0;

    set_region_counter #(.COORD_W(COORD_W), .RAD_W(RAD_W), .GRID_N(GRID_N)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .central   (central),
        .radius    (radius),
        .mode      (mode),
`ifdef SET_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .valid     (valid),
        .candidate (candidate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Enumerates the grid directly from the set rules.
    function automatic int ref_count(input int xa, input int ya, input int xb, input int yb,
                                     input int ra, input int rb, input int m);
        int cnt = 0;
        for (int px = 1; px <= GRID_N; px++) begin
            for (int py = 1; py <= GRID_N; py++) begin
                bit a = ((px-xa)*(px-xa) + (py-ya)*(py-ya)) <= ra*ra;
                bit b = ((px-xb)*(px-xb) + (py-yb)*(py-yb)) <= rb*rb;
                bit s;
                case (m)
                    0:       s = a;
                    1:       s = a && b;
                    2:       s = a != b;
                    default: s = a || b;
                endcase
                if (s) cnt++;
            end
        end
        return cnt;
    endfunction

    // Called #1 after an edge with the DUT idle or in its valid cycle.
    task automatic start_scan(input string tag, input int xa, input int ya, input int xb,
                              input int yb, input int ra, input int rb, input int m);
        central = {xa[COORD_W-1:0], ya[COORD_W-1:0], xb[COORD_W-1:0], yb[COORD_W-1:0]};
        radius  = {ra[RAD_W-1:0], rb[RAD_W-1:0]};
        mode    = m[1:0];
        en      = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        check({tag, "_busy_on_accept"}, 32'(busy), 32'd1);
        check({tag, "_cand_cleared"}, 32'(candidate), 32'd0);
    endtask

    // Waits for valid (bounded), checking latency and count; optionally disturbs inputs mid-scan.
    task automatic wait_result(input string tag, input int exp, input bit perturb);
        int cyc = 0;
        while (cyc < 4 * NPTS) begin
            @(posedge clk);
            #1;
            cyc++;
            if (perturb && cyc == 10) begin
                en      = 1'b1;
                central = 16'($urandom);
                radius  = 8'($urandom);
                mode    = 2'($urandom);
            end
            if (perturb && cyc == 12) en = 1'b0;
            if (valid) break;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(NPTS));
        check({tag, "_count"}, 32'(candidate), 32'(exp));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    task automatic check_hold(input string tag, input int exp);
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, 32'(valid), 32'd0);
        check({tag, "_hold"}, 32'(candidate), 32'(exp));
        check({tag, "_no_restart"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst     = 1'b0;
        en      = 1'b0;
        central = '0;
        radius  = '0;
        mode    = 2'b00;
`ifdef SET_ABORT_EN
        abort   = 1'b0;
`endif
        #3;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_cand", 32'(candidate), 32'd0);
        #9 rst = 1'b1;
        @(posedge clk);
        #1;

        // Single circle, then back-to-back set modes against a second circle.
        start_scan("a_only", 4, 4, 0, 0, 2, 0, 0);
        wait_result("a_only", 13, 1'b0);
        start_scan("and", 4, 4, 6, 4, 2, 2, 1);
        wait_result("and", 5, 1'b0);
        start_scan("xor", 4, 4, 6, 4, 2, 2, 2);
        wait_result("xor", 16, 1'b0);
        start_scan("or", 4, 4, 6, 4, 2, 2, 3);
        wait_result("or", 21, 1'b0);
        check_hold("or", 21);

        // Boundary cases: zero radius, off-grid centre, radius covering the whole grid.
        start_scan("r0", 1, 1, 0, 0, 0, 0, 0);
        wait_result("r0", 1, 1'b0);
        check_hold("r0", 1);
        start_scan("origin", 0, 0, 0, 0, 1, 0, 0);
        wait_result("origin", 0, 1'b0);
        check_hold("origin", 0);
        start_scan("full", 8, 8, 0, 0, 15, 0, 0);
        wait_result("full", 64, 1'b0);
        check_hold("full", 64);

        // Input changes and en pulses during the scan must be ignored.
        start_scan("perturb", 4, 4, 6, 4, 2, 2, 2);
        wait_result("perturb", 16, 1'b1);
        check_hold("perturb", 16);

        // Random operands against the reference model.
        for (int i = 0; i < 8; i++) begin
            int xa = $urandom_range(0, 15);
            int ya = $urandom_range(0, 15);
            int xb = $urandom_range(0, 15);
            int yb = $urandom_range(0, 15);
            int ra = $urandom_range(0, 15);
            int rb = $urandom_range(0, 15);
            int m  = $urandom_range(0, 3);
            int e  = ref_count(xa, ya, xb, yb, ra, rb, m);
            start_scan($sformatf("rnd%0d", i), xa, ya, xb, yb, ra, rb, m);
            wait_result($sformatf("rnd%0d", i), e, 1'b0);
        end
        check_hold("rnd_last", 32'(candidate));

        // Asynchronous reset in the middle of a scan.
        start_scan("rst_mid", 4, 4, 0, 0, 2, 0, 0);
        repeat (30) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_valid", 32'(valid), 32'd0);
        check("rst_mid_cand", 32'(candidate), 32'd0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        start_scan("after_rst", 4, 4, 0, 0, 2, 0, 0);
        wait_result("after_rst", 13, 1'b0);
        check_hold("after_rst", 13);

`ifdef SET_ABORT_EN
        start_scan("abort", 4, 4, 0, 0, 2, 0, 0);
        repeat (19) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cand", 32'(candidate), 32'd0);
        begin
            bit seen = 1'b0;
            repeat (NPTS) begin
                @(posedge clk);
                #1;
                if (valid || busy) seen = 1'b1;
            end
            check("abort_no_valid", 32'(seen), 32'd0);
        end
        start_scan("post_abort", 4, 4, 0, 0, 2, 0, 0);
        wait_result("post_abort", 13, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_set_region_counter
